// File: rtl/mem_fill_arbiter.sv
// Shares one multi-cycle main-memory read port between the I-cache and D-cache fill engines.
// A granted fill issues one word address per cycle, then returning beats are routed to the owner.
module mem_fill_arbiter #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    localparam int WORD_W     = $clog2(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_data_valid,
    output logic              i_grant,
    output logic              d_grant,
    output logic [DATA_W-1:0] fill_data,
    output logic [WORD_W-1:0] fill_word,
    output logic              i_fill_valid,
    output logic              d_fill_valid,
    output logic              i_done,
    output logic              d_done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(4'hF);

    logic [1:0]        state;
    logic              owner;      // 0 = I-cache, 1 = D-cache; holds last owner while idle
    logic [WORD_W-1:0] issue_cnt;
    logic [WORD_W-1:0] rx_cnt;
    logic [ADDR_W-1:0] base;

    logic              busy;
    logic              start;
    logic              pick_d;
    logic              beat;
    logic              last_beat;
    logic [ADDR_W-1:0] win_addr;

    // On a tie the requester that was not served last wins.
    assign busy      = (state == ISSUE) || (state == DRAIN);
    assign start     = (state == IDLE) && (i_req || d_req);
    assign pick_d    = d_req && (!i_req || !owner);
    assign win_addr  = pick_d ? d_addr : i_addr;
    assign beat      = busy && mem_data_valid;
    assign last_beat = beat && (rx_cnt == LAST_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            issue_cnt <= '0;
            rx_cnt    <= '0;
        end else if (last_beat) begin
            state     <= IDLE;
            issue_cnt <= '0;
            rx_cnt    <= '0;
        end else begin
            if (beat) begin
                rx_cnt <= rx_cnt + WORD_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        owner <= pick_d;
                    end
                end
                ISSUE: begin
                    issue_cnt <= issue_cnt + WORD_W'(1);
                    if (issue_cnt == LAST_WORD) begin
                        state <= DRAIN;
                    end
                end
                DRAIN:   state <= DRAIN;
                default: state <= IDLE;
            endcase
        end
    end

    // Block base is captured with the grant; the low nibble is forced to zero so offsets never carry.
    always_ff @(posedge clk) begin
        if (start) begin
            base <= win_addr & BASE_MASK;
        end
    end

    assign mem_en       = (state == ISSUE);
    assign mem_addr     = mem_en ? (base + ADDR_W'({issue_cnt, 1'b0})) : '0;

    assign i_grant      = busy && !owner;
    assign d_grant      = busy && owner;

    assign fill_data    = mem_data;
    assign fill_word    = rx_cnt;
    assign i_fill_valid = beat && !owner;
    assign d_fill_valid = beat && owner;
    assign i_done       = last_beat && !owner;
    assign d_done       = last_beat && owner;

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Shares the single multi-cycle main-memory read port between the I-cache and D-cache fill state machines.
- Arbitrates block-fill requests and issues one word address per cycle for a full cache block.
- Counts the returning data beats and routes them, with a word index, to the granted requester.
- Signals completion so the granted requester can write its tag array; arbitration then reopens.

Parameters:
- BLOCK_WORDS, 8: 16-bit words per cache block; must be a power of 2.
- ADDR_W, 16: byte address width.
- DATA_W, 16: memory data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  I-cache fill request; held high until i_done.
- i_addr  in  ADDR_W  I-cache miss address.
- d_req  in  1  D-cache fill request; held high until d_done.
- d_addr  in  ADDR_W  D-cache miss address.
- mem_en  out  1  memory read enable, one address per cycle.
- mem_addr  out  ADDR_W  memory read address.
- mem_data  in  DATA_W  memory read data.
- mem_data_valid  in  1  mem_data valid; returns in issue order.
- i_grant  out  1  I-cache owns the memory port.
- d_grant  out  1  D-cache owns the memory port.
- fill_data  out  DATA_W  mem_data passed through to both caches.
- fill_word  out  log2(BLOCK_WORDS)  word index of the current beat.
- i_fill_valid  out  1  mem_data_valid gated by i_grant.
- d_fill_valid  out  1  mem_data_valid gated by d_grant.
- i_done  out  1  single-cycle pulse on the last I-cache beat.
- d_done  out  1  single-cycle pulse on the last D-cache beat.

Behaviour:
- Reset values: state IDLE; i_grant=d_grant=0; mem_en=0; mem_addr=0; issue and receive counters 0; last_owner=I.
  - Combinational outputs follow from these values: fill_word=0, fill valids=0, dones=0.
- State machine IDLE -> ISSUE -> DRAIN -> IDLE. One flop holds the owner.
- IDLE:
  - Only i_req: register grant to I. Only d_req: register grant to D.
  - Both requests: grant the requester that is not last_owner. After reset, D therefore wins the first tie.
  - Next state ISSUE. Latch base = {addr[ADDR_W-1:4], 4'h0} from the winner. Grant is high starting the next cycle.
- ISSUE:
  - mem_en=1; mem_addr = base + 2*issue_cnt.
  - issue_cnt increments every cycle.
  - After BLOCK_WORDS issue cycles, go to DRAIN with mem_en=0.
- DRAIN, and also ISSUE (beats may arrive while issuing):
  - Each mem_data_valid increments rx_cnt.
  - fill_word = rx_cnt, combinational; the owner's fill_valid = mem_data_valid.
- Completion:
  - On a valid beat with rx_cnt == BLOCK_WORDS-1, the owner's done pulses in the same cycle.
  - Next cycle: grant drops, last_owner updates, counters clear, state is IDLE.
  - Earliest re-grant is one cycle after that.
- Latency, 4-cycle memory: request seen in cycle 0; grant and first address in cycle 1; addresses in cycles 1-8; beats in cycles 5-12; done in cycle 12; IDLE in cycle 13; next grant in cycle 14.
- Ignored events:
  - mem_data_valid in IDLE is ignored; no fill_valid, no counting.
  - The owner dropping req mid-fill does not abort; the block completes.
  - The loser's req is held off with no timeout.
- Address arithmetic: mem_addr is truncated to ADDR_W. The block base is aligned, so offsets 0..14 never carry past bit 3 and never wrap.
- Grant invariant: i_grant and d_grant are never both 1.
- Reset mid-fill: everything returns to reset values immediately. Data still in flight is not tracked; the memory model is reset together with this block.

Test Plan:
- Single I-fill: i_req=1, i_addr=0x1236 -> i_grant high from cycle 1; mem_addr 0x1230,0x1232,...,0x123E in cycles 1-8; fill_word 0..7 with i_fill_valid; i_done in cycle 12; d_fill_valid stays 0.
- Tie after reset: i_req=d_req=1 in cycle 0 -> D is granted first (d_addr=0xA0F0 gives addresses 0xA0F0..0xA0FE). I is granted 2 cycles after d_done. A second tie afterwards favours D again, since I was served last.
- Back-to-back same requester: d_req held continuously for two fills -> grant drops for exactly 1 cycle between fills, and the second base is re-latched.
- Late request during a fill: i_req rises in cycle 3 of a D fill -> no i_grant until D completes; mem_en shows exactly 8 pulses per fill; the grants are never overlapping.
- Noise and abort: mem_data_valid pulsed in IDLE -> no fill_valid and counters unchanged. The owner drops req mid-fill -> the fill still completes with 8 beats and a done pulse.
- Reset mid-fill: assert rst in cycle 6 -> grant, mem_en and counters go to 0 asynchronously. After release, a new i_req restarts from word 0.
